// File: rtl/seg_pkg.sv
// seg_pkg: shared FSM state, dash code and active-low segment patterns for the display stages
package seg_pkg;
  typedef enum logic [1:0] {IDLE, CONV_HI, CONV_LO, COMMIT} state_t;
  localparam logic [3:0] DIGIT_DASH = 4'hF;
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;
  localparam logic [6:0] SEG_OFF = 7'b1111111;
endpackage

// File: rtl/seg_decoder.sv
// seg_decoder: 4-bit digit code to active-low {g,f,e,d,c,b,a} pattern, codes 10-14 dark
module seg_decoder
  import seg_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] seg
);
  always_comb begin
    seg = SEG_OFF;
    case (code)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      DIGIT_DASH: seg = SEG_DASH;
      default: seg = SEG_OFF;
    endcase
  end
endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: snapshots two values, converts each to two decimal digits by repeated subtraction, scans them onto a 4-digit common-anode display
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int WIDTH = 6,
  parameter int REFRESH_DIV = 50000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] value_hi,
  input  logic [WIDTH-1:0] value_lo,
  input  logic             blank,
  output logic             busy,
  output logic [3:0]       an,
  output logic [6:0]       seg,
  output logic             dp
);
  localparam int W = WIDTH + 1;
  localparam int CW = $clog2(REFRESH_DIV);
  state_t state;
  logic [W-1:0] work_hi, work_lo, work;
  logic [3:0] tens;
  logic [3:0] pend [4];
  logic [3:0] disp [4];
  logic [CW-1:0] cnt;
  logic [1:0] idx;
  logic [6:0] seg_code;
  logic hi, ge100, ge10, wrap;
  assign hi = state == CONV_HI;
  assign work = hi ? work_hi : work_lo;
  assign ge100 = int'(work) >= 100;
  assign ge10 = int'(work) >= 10;
  assign wrap = cnt == CW'(REFRESH_DIV - 1);
  // pending digits shield the display so only complete conversions become visible
  always_ff @(posedge clk)
    if (!reset) begin
      state <= IDLE;
      busy <= 1'b0;
      tens <= '0;
      work_hi <= '0;
      work_lo <= '0;
      pend <= '{default: '0};
      disp <= '{default: '0};
    end else
      case (state)
        IDLE:
          if (load) begin
            work_hi <= W'(value_hi);
            work_lo <= W'(value_lo);
            tens <= '0;
            state <= CONV_HI;
            busy <= 1'b1;
          end
        CONV_HI, CONV_LO:
          if (ge100 || !ge10) begin
            pend[{hi, 1'b1}] <= ge100 ? DIGIT_DASH : tens;
            pend[{hi, 1'b0}] <= ge100 ? DIGIT_DASH : 4'(work);
            tens <= '0;
            state <= hi ? CONV_LO : COMMIT;
          end else begin
            if (hi) work_hi <= work_hi - W'(10);
            else work_lo <= work_lo - W'(10);
            tens <= tens + 4'd1;
          end
        COMMIT: begin
          disp <= pend;
          state <= IDLE;
          busy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
  seg_decoder u_dec (
    .code(disp[idx]),
    .seg (seg_code)
  );
  always_ff @(posedge clk)
    if (!reset) begin
      cnt <= '0;
      idx <= '0;
      an <= 4'hF;
      seg <= SEG_OFF;
      dp <= 1'b1;
    end else begin
      cnt <= wrap ? '0 : cnt + CW'(1);
      idx <= idx + 2'(wrap);
      an <= blank ? 4'hF : ~(4'b1 << idx);
      seg <= seg_code;
      dp <= idx != 2'd2;
    end
endmodule
